// File: rtl/shift_reg_univ_n.sv
// Universal WIDTH-bit shift register: shift, rotate, load and hold in either direction.
// It also tracks shifts per frame. Define SHREG_TOGGLE_CNT_EN to build the saturating Q-toggle activity counter.
module shift_reg_univ_n #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         ENB,
  input  logic                         DIR,
  input  logic [1:0]                   MODO,
  input  logic                         S_IN,
  input  logic [WIDTH-1:0]             D,
  output logic [WIDTH-1:0]             Q,
  output logic                         S_OUT,
  output logic [$clog2(WIDTH+1)-1:0]   SH_CNT,
  output logic                         FRAME_DONE,
  output logic [CNT_W-1:0]             PWR_CNT
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  mode_t            w_mode;
  logic             w_moves;
  logic [WIDTH-1:0] w_qNext;
  logic [CW-1:0]    w_cntNext;
  logic             w_frameNext;

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_shCnt;
  logic             r_frameDone;

  assign w_mode  = mode_t'(MODO);
  assign w_moves = (w_mode == MODE_SHIFT) || (w_mode == MODE_ROTATE);

  always_comb begin
    w_qNext = r_q;
    unique case (w_mode)
      MODE_SHIFT:  w_qNext = DIR ? {r_q[WIDTH-2:0], S_IN} : {S_IN, r_q[WIDTH-1:1]};
      MODE_ROTATE: w_qNext = DIR ? {r_q[WIDTH-2:0], r_q[WIDTH-1]} : {r_q[0], r_q[WIDTH-1:1]};
      MODE_LOAD:   w_qNext = D;
      MODE_HOLD:   w_qNext = r_q;
      default:     w_qNext = r_q;
    endcase
  end

  // Saturation at WIDTH is what stops FRAME_DONE re-firing until the next load re-arms it.
  always_comb begin
    w_cntNext = r_shCnt;
    if (w_mode == MODE_LOAD) begin
      w_cntNext = '0;
    end else if (w_moves && (r_shCnt != CNT_SAT)) begin
      w_cntNext = r_shCnt + CW'(1);
    end
  end

  assign w_frameNext = ENB && w_moves && (r_shCnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_q         <= '0;
      r_shCnt     <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_frameNext;
      if (ENB) begin
        r_q     <= w_qNext;
        r_shCnt <= w_cntNext;
      end
    end
  end

  assign Q          = r_q;
  assign SH_CNT     = r_shCnt;
  assign FRAME_DONE = r_frameDone;
  assign S_OUT      = (w_mode == MODE_SHIFT) ? (DIR ? r_q[WIDTH-1] : r_q[0]) : 1'b0;

`ifdef SHREG_TOGGLE_CNT_EN
  logic [CW-1:0]    w_pop;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] r_pwrCnt;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CW'(r_q[i] ^ w_qNext[i]);
    end
  end

  // One spare bit catches the carry so the counter pins at all-ones instead of wrapping.
  assign w_sum = {1'b0, r_pwrCnt} + (CNT_W+1)'(w_pop);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pwrCnt <= '0;
    end else if (ENB) begin
      r_pwrCnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

  assign PWR_CNT = r_pwrCnt;
`else
  assign PWR_CNT = '0;
`endif

endmodule

// File: tb/tb_shift_reg_univ_n.sv
// Self-checking bench for shift_reg_univ_n: a 4-bit and an 8-bit (CNT_W=3) instance share controls
// and are compared against an arithmetic reference model under directed and random stimulus.
module tb_shift_reg_univ_n;

`ifdef SHREG_TOGGLE_CNT_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic       CLK;
  logic       RSTn;
  logic       ENB;
  logic       DIR;
  logic [1:0] MODO;
  logic       S_IN;
  logic [3:0] d4;
  logic [7:0] d8;

  logic [3:0]  q4;
  logic        sOut4;
  logic [2:0]  shCnt4;
  logic        fd4;
  logic [15:0] pwr4;

  logic [7:0]  q8;
  logic        sOut8;
  logic [3:0]  shCnt8;
  logic        fd8;
  logic [2:0]  pwr8;

  int checks = 0;
  int failures = 0;

  int wArr[2]   = '{4, 8};
  int pwrMax[2] = '{65535, 7};
  int mq[2];
  int mcnt[2];
  int mfd[2];
  int mpwr[2];

  shift_reg_univ_n #(.WIDTH(4), .CNT_W(16)) dut4 (
    .CLK(CLK), .RSTn(RSTn), .ENB(ENB), .DIR(DIR), .MODO(MODO), .S_IN(S_IN), .D(d4),
    .Q(q4), .S_OUT(sOut4), .SH_CNT(shCnt4), .FRAME_DONE(fd4), .PWR_CNT(pwr4)
  );

  shift_reg_univ_n #(.WIDTH(8), .CNT_W(3)) dut8 (
    .CLK(CLK), .RSTn(RSTn), .ENB(ENB), .DIR(DIR), .MODO(MODO), .S_IN(S_IN), .D(d8),
    .Q(q8), .S_OUT(sOut8), .SH_CNT(shCnt8), .FRAME_DONE(fd8), .PWR_CNT(pwr8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  function automatic int modelNext(input int q, input int w, input int mode, input int dir, input int sin, input int d);
    int mask;
    mask = (1 << w) - 1;
    case (mode)
      0: return dir ? (((q << 1) | sin) & mask) : ((q >> 1) | (sin << (w-1)));
      1: return dir ? (((q << 1) | (q >> (w-1))) & mask) : ((q >> 1) | ((q & 1) << (w-1)));
      2: return d & mask;
      default: return q;
    endcase
  endfunction

  function automatic int modelSout(input int q, input int w, input int mode, input int dir);
    if (mode != 0) return 0;
    return dir ? ((q >> (w-1)) & 1) : (q & 1);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = 0; mcnt[k] = 0; mfd[k] = 0; mpwr[k] = 0;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " q4"},     32'(q4),     32'(mq[0]));
    checkOutput({tag, " cnt4"},   32'(shCnt4), 32'(mcnt[0]));
    checkOutput({tag, " fd4"},    32'(fd4),    32'(mfd[0]));
    checkOutput({tag, " pwr4"},   32'(pwr4),   TOG_EN ? 32'(mpwr[0]) : 32'd0);
    checkOutput({tag, " q8"},     32'(q8),     32'(mq[1]));
    checkOutput({tag, " cnt8"},   32'(shCnt8), 32'(mcnt[1]));
    checkOutput({tag, " fd8"},    32'(fd8),    32'(mfd[1]));
    checkOutput({tag, " pwr8"},   32'(pwr8),   TOG_EN ? 32'(mpwr[1]) : 32'd0);
  endtask

  // Called at a falling edge: drive, check S_OUT, take one rising edge, advance the model, check.
  task automatic applyStimulus(input string tag, input int enb, input int dir, input int mode,
                               input int sin, input int dv4, input int dv8);
    int nq;
    int dArr[2];
    ENB = 1'(enb); DIR = 1'(dir); MODO = 2'(mode); S_IN = 1'(sin);
    d4 = 4'(dv4); d8 = 8'(dv8);
    dArr[0] = dv4; dArr[1] = dv8;
    #1;
    checkOutput({tag, " sout4"}, 32'(sOut4), 32'(modelSout(mq[0], 4, mode, dir)));
    checkOutput({tag, " sout8"}, 32'(sOut8), 32'(modelSout(mq[1], 8, mode, dir)));
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      mfd[k] = (enb != 0 && mode <= 1 && mcnt[k] == wArr[k] - 1) ? 1 : 0;
      if (enb != 0) begin
        nq = modelNext(mq[k], wArr[k], mode, dir, sin, dArr[k]);
        mpwr[k] = mpwr[k] + $countones(32'(nq ^ mq[k]));
        if (mpwr[k] > pwrMax[k]) mpwr[k] = pwrMax[k];
        mq[k] = nq;
        if (mode == 2) mcnt[k] = 0;
        else if (mode <= 1 && mcnt[k] < wArr[k]) mcnt[k]++;
      end
    end
    @(negedge CLK);
    checkAll(tag);
  endtask

  // Reset pulse placed between edges; outputs must clear without any clock edge.
  task automatic pulseReset(input string tag);
    ENB = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    #1 RSTn = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    RSTn = 1'b0; ENB = 1'b0; DIR = 1'b0; MODO = 2'b11; S_IN = 1'b0; d4 = '0; d8 = '0;
    modelReset();
    #3;
    checkAll("reset");
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);

    applyStimulus("load", 1, 0, 2, 0, 4'b1011, 8'hB5);
    pulseReset("midreset");

    applyStimulus("load", 1, 0, 2, 0, 4'b1011, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus("shl", 1, 1, 0, 0, 0, 0);
    checkOutput("shl final q4", 32'(q4), 32'h0);
    checkOutput("shl sat cnt4", 32'(shCnt4), 32'd4);

    applyStimulus("load", 1, 0, 2, 0, 4'b1011, 8'h96);
    for (int i = 0; i < 4; i++) applyStimulus("rotr", 1, 0, 1, 0, 0, 0);
    checkOutput("rotr final q4", 32'(q4), 32'hB);

    applyStimulus("load", 1, 0, 2, 0, 4'b1011, 8'h3C);
    for (int i = 0; i < 3; i++) applyStimulus("enb0", 0, 1, 0, 1, 0, 0);
    applyStimulus("hold", 1, 1, 3, 1, 0, 0);
    checkOutput("hold q4", 32'(q4), 32'hB);

    pulseReset("rst2");
    for (int i = 0; i < 8; i++) applyStimulus("shr1", 1, 0, 0, 1, 0, 0);
    checkOutput("shr1 q8", 32'(q8), 32'hFF);
    checkOutput("shr1 fd8", 32'(fd8), 32'd1);

    applyStimulus("tog", 1, 0, 2, 0, 4'hF, 8'hFF);
    applyStimulus("tog", 1, 0, 2, 0, 4'h0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) pulseReset("rrst");
      else applyStimulus("rand", ($urandom_range(0, 7) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                         int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
